// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds issued ALU ops until both operands are
// available, snoops two CDBs for wakeup and dispatches one ready entry per cycle.
`ifndef TYPE_BIT
`define TYPE_BIT 4
`endif
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module alu_issue_queue #(
  parameter int RS_SIZE = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic [`TYPE_BIT-1:0]      issue_type,
  input  logic [`ROB_INDEX_BIT-1:0] issue_rob_id,
  input  logic [31:0]               issue_vj,
  input  logic [31:0]               issue_vk,
  input  logic                      issue_qj_busy,
  input  logic                      issue_qk_busy,
  input  logic [`ROB_INDEX_BIT-1:0] issue_qj,
  input  logic [`ROB_INDEX_BIT-1:0] issue_qk,
  input  logic                      cdb0_valid,
  input  logic [`ROB_INDEX_BIT-1:0] cdb0_rob_id,
  input  logic [31:0]               cdb0_value,
  input  logic                      cdb1_valid,
  input  logic [`ROB_INDEX_BIT-1:0] cdb1_rob_id,
  input  logic [31:0]               cdb1_value,
  output logic                      full,
  output logic                      alu_req,
  output logic [`TYPE_BIT-1:0]      alu_type,
  output logic [31:0]               alu_r1,
  output logic [31:0]               alu_r2,
  output logic [`ROB_INDEX_BIT-1:0] alu_rob_id
);

  localparam int TW = `TYPE_BIT;
  localparam int RW = `ROB_INDEX_BIT;
  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic          valid_q   [RS_SIZE];
  logic          valid_d   [RS_SIZE];
  logic [TW-1:0] type_q    [RS_SIZE];
  logic [TW-1:0] type_d    [RS_SIZE];
  logic [RW-1:0] rob_q     [RS_SIZE];
  logic [RW-1:0] rob_d     [RS_SIZE];
  logic [31:0]   vj_q      [RS_SIZE];
  logic [31:0]   vj_d      [RS_SIZE];
  logic [31:0]   vk_q      [RS_SIZE];
  logic [31:0]   vk_d      [RS_SIZE];
  logic          qj_busy_q [RS_SIZE];
  logic          qj_busy_d [RS_SIZE];
  logic          qk_busy_q [RS_SIZE];
  logic          qk_busy_d [RS_SIZE];
  logic [RW-1:0] qj_q      [RS_SIZE];
  logic [RW-1:0] qj_d      [RS_SIZE];
  logic [RW-1:0] qk_q      [RS_SIZE];
  logic [RW-1:0] qk_d      [RS_SIZE];

  logic          alu_req_q, alu_req_d;
  logic [TW-1:0] alu_type_q, alu_type_d;
  logic [31:0]   alu_r1_q, alu_r1_d;
  logic [31:0]   alu_r2_q, alu_r2_d;
  logic [RW-1:0] alu_rob_id_q, alu_rob_id_d;

  logic          full_s;
  logic          sel_found_s;
  logic [IW-1:0] sel_idx_s;
  logic [IW-1:0] free_idx_s;

  // Resolve a pending operand against both CDBs; cdb0 wins on a tag tie.
  // Returns {still_busy, value}.
  function automatic logic [32:0] resolve(input logic busy, input logic [RW-1:0] tag,
                                          input logic [31:0] val);
    if (!busy) begin
      resolve = {1'b0, val};
    end else if (cdb0_valid && (cdb0_rob_id == tag)) begin
      resolve = {1'b0, cdb0_value};
    end else if (cdb1_valid && (cdb1_rob_id == tag)) begin
      resolve = {1'b0, cdb1_value};
    end else begin
      resolve = {1'b1, val};
    end
  endfunction

  assign full       = full_s;
  assign alu_req    = alu_req_q;
  assign alu_type   = alu_type_q;
  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
  assign alu_rob_id = alu_rob_id_q;

  always_comb begin
    logic [32:0] rj;
    logic [32:0] rk;
    valid_d      = valid_q;
    type_d       = type_q;
    rob_d        = rob_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_busy_d    = qj_busy_q;
    qk_busy_d    = qk_busy_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    alu_req_d    = alu_req_q;
    alu_type_d   = alu_type_q;
    alu_r1_d     = alu_r1_q;
    alu_r2_d     = alu_r2_q;
    alu_rob_id_d = alu_rob_id_q;
    full_s       = 1'b1;
    sel_found_s  = 1'b0;
    sel_idx_s    = '0;
    free_idx_s   = '0;
    rj           = 33'd0;
    rk           = 33'd0;

    // Downward scans leave the lowest matching index in the result.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        full_s     = 1'b0;
        free_idx_s = IW'(i);
      end
      if (valid_q[i] && !qj_busy_q[i] && !qk_busy_q[i]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IW'(i);
      end
    end

    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        valid_d[i] = 1'b0;
      end
      alu_req_d = 1'b0;
    end else begin
      alu_req_d = sel_found_s;
      if (sel_found_s) begin
        alu_type_d          = type_q[sel_idx_s];
        alu_r1_d            = vj_q[sel_idx_s];
        alu_r2_d            = vk_q[sel_idx_s];
        alu_rob_id_d        = rob_q[sel_idx_s];
        valid_d[sel_idx_s]  = 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid_q[i]) begin
          rj           = resolve(qj_busy_q[i], qj_q[i], vj_q[i]);
          rk           = resolve(qk_busy_q[i], qk_q[i], vk_q[i]);
          qj_busy_d[i] = rj[32];
          vj_d[i]      = rj[31:0];
          qk_busy_d[i] = rk[32];
          vk_d[i]      = rk[31:0];
        end
      end
      // A slot freed by this cycle's dispatch is not reused until next cycle.
      if (issue_valid && !full_s) begin
        rj                    = resolve(issue_qj_busy, issue_qj, issue_vj);
        rk                    = resolve(issue_qk_busy, issue_qk, issue_vk);
        valid_d[free_idx_s]   = 1'b1;
        type_d[free_idx_s]    = issue_type;
        rob_d[free_idx_s]     = issue_rob_id;
        qj_d[free_idx_s]      = issue_qj;
        qk_d[free_idx_s]      = issue_qk;
        qj_busy_d[free_idx_s] = rj[32];
        vj_d[free_idx_s]      = rj[31:0];
        qk_busy_d[free_idx_s] = rk[32];
        vk_d[free_idx_s]      = rk[31:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        valid_q[i]   <= 1'b0;
        type_q[i]    <= '0;
        rob_q[i]     <= '0;
        vj_q[i]      <= 32'd0;
        vk_q[i]      <= 32'd0;
        qj_busy_q[i] <= 1'b0;
        qk_busy_q[i] <= 1'b0;
        qj_q[i]      <= '0;
        qk_q[i]      <= '0;
      end
      alu_req_q    <= 1'b0;
      alu_type_q   <= '0;
      alu_r1_q     <= 32'd0;
      alu_r2_q     <= 32'd0;
      alu_rob_id_q <= '0;
    end else if (rdy_in) begin
      valid_q      <= valid_d;
      type_q       <= type_d;
      rob_q        <= rob_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_busy_q    <= qj_busy_d;
      qk_busy_q    <= qk_busy_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      alu_req_q    <= alu_req_d;
      alu_type_q   <= alu_type_d;
      alu_r1_q     <= alu_r1_d;
      alu_r2_q     <= alu_r2_d;
      alu_rob_id_q <= alu_rob_id_d;
    end else begin
      valid_q <= valid_q;
    end
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameters: RS_SIZE, default 4, number of queue entries; widths `TYPE_BIT and `ROB_INDEX_BIT come from const.v.
REQ-002 clk_in  input  1  clock; all state changes on the rising edge.
REQ-003 rst_in  input  1  reset; synchronous and active-high.
REQ-004 rdy_in  input  1  global ready; low pauses the block.
REQ-005 flush  input  1  misprediction clear.
REQ-006 issue_valid  input  1  new instruction presented this cycle.
REQ-007 issue_type  input  `TYPE_BIT  operation code.
REQ-008 issue_rob_id  input  `ROB_INDEX_BIT  destination ROB tag.
REQ-009 issue_vj, issue_vk  input  32 each  operand values.
REQ-010 issue_qj_busy, issue_qk_busy  input  1 each  high when the operand is still pending.
REQ-011 issue_qj, issue_qk  input  `ROB_INDEX_BIT each  producer tags of pending operands.
REQ-012 cdb0_valid / cdb0_rob_id / cdb0_value  input  1 / `ROB_INDEX_BIT / 32  ALU result broadcast.
REQ-013 cdb1_valid / cdb1_rob_id / cdb1_value  input  1 / `ROB_INDEX_BIT / 32  load/store result broadcast.
REQ-014 full  output  1  high when all RS_SIZE entries are valid.
REQ-015 alu_req  output  1  registered request to the ALU.
REQ-016 alu_type  output  `TYPE_BIT  registered operation code to the ALU.
REQ-017 alu_r1, alu_r2  output  32 each  registered operands to the ALU.
REQ-018 alu_rob_id  output  `ROB_INDEX_BIT  registered tag to the ALU.

Function
REQ-019 Each entry SHALL hold: valid, type, rob_id, vj, vk, qj_busy, qk_busy, qj, qk.
REQ-020 full SHALL be combinational from the registered valid bits only.
REQ-021 Issue, when accepted, SHALL write the lowest-index invalid entry on the clock edge.
REQ-022 Issue SHALL be ignored when full=1; no entry is overwritten.
REQ-023 Wakeup: for each valid entry with qj_busy=1 and a cdbN_valid with cdbN_rob_id==qj, the block SHALL set vj<=cdbN_value and qj_busy<=0; the same rule applies to qk.
REQ-024 Issue bypass: if an issued operand is pending and its tag matches a CDB broadcast in the same cycle, the entry SHALL be written with the broadcast value and busy=0.
REQ-025 If both CDBs match the same tag, cdb0 SHALL take priority.
REQ-026 An entry is ready when valid=1, qj_busy=0 and qk_busy=0, evaluated on registered state.
REQ-027 Each cycle the lowest-index ready entry SHALL be selected.
REQ-028 On the edge after selection: alu_req<=1, alu_type/alu_r1/alu_r2/alu_rob_id<=that entry's type/vj/vk/rob_id, and the entry is invalidated; alu_req<=0 when no entry is ready.
REQ-029 Dispatch rate SHALL be at most one entry per cycle.
REQ-030 Minimum latency from issue with ready operands to alu_req=1 SHALL be 2 cycles (write, then select).
REQ-031 An entry woken by a CDB SHALL be dispatched no earlier than the cycle after the wakeup.
REQ-032 An entry freed by dispatch SHALL become writable from the next cycle; full deasserts that cycle.
REQ-033 Concurrent issue and dispatch in one cycle SHALL both take effect, including when full=0 with exactly one free slot.
REQ-034 flush=1 SHALL, on the next edge, clear all valid bits and set alu_req<=0; flush has priority over issue, wakeup and dispatch.
REQ-035 rdy_in=0 (without reset) SHALL hold every register, alu_req included; issue and CDB inputs that cycle are dropped.

Reset
REQ-036 rst_in=1 at an edge SHALL clear all valid and busy bits and set alu_req, alu_type, alu_r1, alu_r2 and alu_rob_id to 0.
REQ-037 Reset SHALL override rdy_in, flush, issue and wakeup, including when asserted mid-operation.
REQ-038 After reset, full SHALL be 0.

Verification
REQ-039 Issue ADD vj=5 vk=7 rob=3, both operands ready -> alu_req=1, alu_type=ADD, r1=5, r2=7, alu_rob_id=3 exactly 2 cycles after issue; alu_req=0 the following cycle.
REQ-040 Issue SUB with qj_busy=1, qj=2, vk=1; broadcast cdb1 rob=2 value=10 three cycles later -> dispatch with r1=10, r2=1 one cycle after the wakeup edge+1.
REQ-041 Issue four dependent entries -> full=1; fifth issue ignored; wake entry 2 -> it dispatches, full=0, and the next issue lands in slot 2.
REQ-042 Issue with qk=4 pending in the same cycle cdb0 broadcasts rob=4 value=0xFFFFFFFF -> entry captures the bypassed value and dispatches 2 cycles later with r2=0xFFFFFFFF.
REQ-043 Three entries ready, flush asserted -> next cycle alu_req=0, full=0, and no further dispatch.
REQ-044 rdy_in low for 3 cycles with a ready entry -> outputs frozen; dispatch resumes on the first rdy_in=1 edge; rst_in mid-stream -> all outputs 0 next cycle.
